// File: rtl/lab4_pkg.sv
// Shared lab4 definitions: ROM geometry, loader state encoding and the ROM golden table.
package lab4_pkg;
  localparam int LAB4_ADDR_W = 4;
  localparam int LAB4_DATA_W = 5;
  localparam int LAB4_DEPTH  = 1 << LAB4_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    FIN  = 2'd2
  } loaderState_t;

  // Contents of lab4ROM, address 0 first.
  localparam logic [LAB4_DATA_W-1:0] LAB4_ROM_TABLE [LAB4_DEPTH] = '{
    5'b00000, 5'b00001, 5'b00110, 5'b00111,
    5'b01011, 5'b01100, 5'b01101, 5'b01110,
    5'b11101, 5'b11110, 5'b11111, 5'b10000,
    5'b10111, 5'b11000, 5'b11001, 5'b11010
  };
endpackage

// File: rtl/lab4_ram16x5.sv
// Single-write-port RAM with registered, read-before-write read port and synchronous clear.
module lab4_ram16x5
  import lab4_pkg::*;
#(
  parameter int ADDR_W = LAB4_ADDR_W,
  parameter int DATA_W = LAB4_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Non-blocking read and write in one block give the old word on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rData <= '0;
    end else begin
      rData <= mem[rAddr];
      if (we) begin
        mem[wAddr] <= wData;
      end
    end
  end
endmodule

// File: rtl/lab4_rom_ram_loader.sv
// Copies the 16-word lab4ROM into a local RAM on request, then serves user reads and writes.
module lab4_rom_ram_loader
  import lab4_pkg::*;
#(
  parameter int ADDR_W = LAB4_ADDR_W,
  parameter int DATA_W = LAB4_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  loaderState_t      state;
  logic [ADDR_W-1:0] ptr;

  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramData;

  // ptr wraps to 0 after the last word, so it is already 0 whenever the FSM is idle.
  assign romAddr = ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= COPY;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        COPY: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          done <= 1'b0;
          if (start) begin
            state <= COPY;
            ptr   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The copy owns the write port while busy; user writes in that window are simply lost.
  always_comb begin
    ramWe   = 1'b0;
    ramAddr = wrAddr;
    ramData = wrData;
    if (busy) begin
      ramWe   = 1'b1;
      ramAddr = ptr;
      ramData = romData;
    end else if (wrEn) begin
      ramWe   = 1'b1;
    end
  end

  lab4_ram16x5 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uRam (
    .clk  (CLK),
    .rst  (RST),
    .we   (ramWe),
    .wAddr(ramAddr),
    .wData(ramData),
    .rAddr(rdAddr),
    .rData(rdData)
  );
endmodule

// File: tb/tb_lab4_rom_ram_loader.sv
// Directed bench for lab4_rom_ram_loader with a behavioural combinational ROM.
module tb_lab4_rom_ram_loader;
  logic       CLK;
  logic       RST;
  logic       start;
  logic [3:0] romAddr;
  logic [4:0] romData;
  logic       wrEn;
  logic [3:0] wrAddr;
  logic [4:0] wrData;
  logic [3:0] rdAddr;
  logic [4:0] rdData;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [4:0] romTbl [16];

  lab4_rom_ram_loader dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .romAddr(romAddr),
    .romData(romData),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (rdAddr),
    .rdData (rdData),
    .busy   (busy),
    .done   (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb romData = romTbl[romAddr];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if (rdData !== 5'b00000) begin errors++; $display("FAIL reset_rdData got %b want 00000", rdData); end
    RST = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (romAddr !== 4'd0) begin errors++; $display("FAIL reset_romAddr got %0d want 0", romAddr); end
    for (int i = 0; i < 16; i++) begin
      rdAddr = 4'(i);
      tick();
      checks++;
      if (rdData !== 5'b00000) begin errors++; $display("FAIL reset_mem[%0d] got %b want 00000", i, rdData); end
    end
  endtask

  task automatic test_full_copy();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL copy_busy_cycles got %0d want 16", n); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL copy_done got %b want 1", done); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL copy_done_pulse got %b want 0", done); end
    for (int i = 0; i < 16; i++) begin
      rdAddr = 4'(i);
      tick();
      checks++;
      if (rdData !== romTbl[i]) begin
        errors++; $display("FAIL copy_mem[%0d] got %b want %b", i, rdData, romTbl[i]);
      end
    end
  endtask

  task automatic test_write_lockout();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wrAddr = 4'd3;
    wrData = 5'b11111;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      wrEn = (n >= 6 && n < 12);
      n++;
      tick();
    end
    wrEn = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL lockout_busy_cycles got %0d want 16", n); end
    tick();
    rdAddr = 4'd3;
    tick();
    checks++;
    if (rdData !== 5'b00111) begin errors++; $display("FAIL lockout_mem3 got %b want 00111", rdData); end
    wrEn = 1'b1;
    tick();
    wrEn = 1'b0;
    tick();
    checks++;
    if (rdData !== 5'b11111) begin errors++; $display("FAIL idle_write_mem3 got %b want 11111", rdData); end
  endtask

  task automatic test_read_before_write();
    rdAddr = 4'd5;
    wrAddr = 4'd5;
    wrData = 5'b10101;
    wrEn   = 1'b1;
    tick();
    wrEn = 1'b0;
    checks++;
    if (rdData !== 5'b01100) begin errors++; $display("FAIL rbw_old got %b want 01100", rdData); end
    tick();
    checks++;
    if (rdData !== 5'b10101) begin errors++; $display("FAIL rbw_new got %b want 10101", rdData); end
  endtask

  task automatic test_back_to_back();
    int n;
    int dones;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      start = (n == 5);
      n++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL ignore_start_cycles got %0d want 16", n); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_start_done got %0d pulses busy=%b want 1 pulse busy=0", dones, busy);
    end
    // Second run: restart in the FIN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL fin_done got %b want 1", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL fin_restart busy=%b done=%b want 1 0", busy, done);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16 || done !== 1'b1) begin
      errors++; $display("FAIL fin_second_copy cycles=%0d done=%b want 16 1", n, done);
    end
    rdAddr = 4'd3;
    tick();
    checks++;
    if (rdData !== 5'b00111) begin errors++; $display("FAIL recopy_mem3 got %b want 00111", rdData); end
    rdAddr = 4'd5;
    tick();
    checks++;
    if (rdData !== 5'b01100) begin errors++; $display("FAIL recopy_mem5 got %b want 01100", rdData); end
  endtask

  task automatic test_reset_mid_copy();
    int dones;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (romAddr !== 4'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL midcopy_ptr romAddr=%0d busy=%b want 7 1", romAddr, busy);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || romAddr !== 4'd0) begin
      errors++; $display("FAIL midreset_flags busy=%b done=%b romAddr=%0d want 0 0 0", busy, done, romAddr);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midreset_activity got %0d active cycles want 0", dones); end
    for (int i = 0; i < 16; i++) begin
      rdAddr = 4'(i);
      tick();
      checks++;
      if (rdData !== 5'b00000) begin errors++; $display("FAIL midreset_mem[%0d] got %b want 00000", i, rdData); end
    end
  endtask

  initial begin
    romTbl = '{5'b00000, 5'b00001, 5'b00110, 5'b00111,
               5'b01011, 5'b01100, 5'b01101, 5'b01110,
               5'b11101, 5'b11110, 5'b11111, 5'b10000,
               5'b10111, 5'b11000, 5'b11001, 5'b11010};
    RST    = 1'b1;
    start  = 1'b0;
    wrEn   = 1'b0;
    wrAddr = 4'd0;
    wrData = 5'd0;
    rdAddr = 4'd0;
    test_reset();
    test_full_copy();
    test_write_lockout();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
